// File: rtl/bsub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state type and
// counter width helper.
package bsub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bsub_state_e;

    // Width of a counter that indexes 0 .. width-1.
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, bout on underflow.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference and borrow-out of one bit position.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B - Bin, LSB first, one bit per clock,
// valid/ready handshake on input and output.
// Optional build macro BSUB_SATURATE_EN: clamp Diff to zero on final borrow.
module bit_serial_subtractor
    import bsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Zero
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    bsub_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] diff_sr_q;
    logic             borrow_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             zero_q;

    logic             cell_d;
    logic             cell_bout;
    logic [WIDTH-1:0] diff_sr_d;
    logic [WIDTH-1:0] diff_d;
    logic             zero_d;

    full_subtractor u_cell (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (borrow_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Next shifted difference and the result that would be published this edge.
    always_comb begin
        diff_sr_d = {cell_d, diff_sr_q[WIDTH-1:1]};
`ifdef BSUB_SATURATE_EN
        if (cell_bout) begin
            diff_d = '0;
            zero_d = 1'b1;
        end else begin
            diff_d = diff_sr_d;
            zero_d = (diff_sr_d == '0);
        end
`else
        diff_d = diff_sr_d;
        zero_d = (diff_sr_d == '0);
`endif
    end

    // FSM, datapath shift registers and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            diff_sr_q   <= '0;
            borrow_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sr_q     <= A;
                        b_sr_q     <= B;
                        borrow_q   <= Bin;
                        diff_sr_q  <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    diff_sr_q <= diff_sr_d;
                    borrow_q  <= cell_bout;
                    a_sr_q    <= {1'b0, a_sr_q[WIDTH-1:1]};
                    b_sr_q    <= {1'b0, b_sr_q[WIDTH-1:1]};
                    cnt_q     <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        diff_q      <= diff_d;
                        bout_q      <= cell_bout;
                        zero_q      <= zero_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Diff      = diff_q;
    assign Bout      = bout_q;
    assign Zero      = zero_q;

endmodule
